// File: rtl/i2s_pkg.sv
// Shared constants, mixer FSM states and accumulator sizing
// for the I2S frame scheduler.
package i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int WORD_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SCAN,
    REQ,
    GAP,
    DONE
  } mix_state_e;

  function automatic int acc_width(input int sample_w, input int num_voices);
    return sample_w + $clog2(num_voices);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit clock, word select and frame boundary pulse derived
// from the system clock.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int SCLK_HALF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic sclk,
  output logic lrclk,
  output logic frame_start
);

  localparam int HW = $clog2(SCLK_HALF);
  localparam int BW = $clog2(FRAME_BITS);

  logic [HW-1:0] half_cnt;
  logic [BW-1:0] bit_cnt;
  logic          half_tc;

  assign half_tc = half_cnt == HW'(SCLK_HALF - 1);
  assign lrclk   = bit_cnt[BW-1];

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      half_cnt    <= '0;
      bit_cnt     <= '0;
      sclk        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Pulse lands in the cycle where sclk has fallen and bit_cnt reads 0
      frame_start <= half_tc && sclk && (bit_cnt == BW'(FRAME_BITS - 1));
      if (half_tc) begin
        half_cnt <= '0;
        sclk     <= ~sclk;
        if (sclk)
          bit_cnt <= bit_cnt + BW'(1);
      end else begin
        half_cnt <= half_cnt + HW'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_mix_sched.sv
// Per-frame voice fetch scheduler and mixer feeding the
// I2S serializer parallel word.
module i2s_mix_sched
  import i2s_pkg::*;
#(
  parameter int SCLK_HALF  = 4,
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_VOICES-1:0]         voice_active,
  output logic                          fetch_req,
  output logic [$clog2(NUM_VOICES)-1:0] fetch_voice,
  input  logic                          fetch_ack,
  input  logic [SAMPLE_W-1:0]           fetch_data,
  output logic                          sclk,
  output logic                          lrclk,
  output logic [WORD_W-1:0]             i2s_word,
  output logic                          frame_start,
  output logic                          underrun
);

  localparam int IW    = $clog2(NUM_VOICES);
  localparam int ACC_W = acc_width(SAMPLE_W, NUM_VOICES);

  mix_state_e            state, state_n;
  logic [IW-1:0]         idx, idx_n;
  logic [ACC_W-1:0]      acc, acc_n;
  logic [NUM_VOICES-1:0] snap, snap_n;
  logic [WORD_W-1:0]     word_n, mix_word;
  logic [ACC_W-1:0]      sample_ext;
  logic                  last;

  i2s_clkgen #(.SCLK_HALF(SCLK_HALF)) u_clkgen (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sclk        (sclk),
    .lrclk       (lrclk),
    .frame_start (frame_start)
  );

  assign last       = idx == IW'(NUM_VOICES - 1);
  assign sample_ext = {{(ACC_W-SAMPLE_W){fetch_data[SAMPLE_W-1]}}, fetch_data};
  assign fetch_req   = state == REQ;
  assign fetch_voice = idx;
  assign underrun    = frame_start && (state != DONE);

  always_comb begin
    mix_word = '0;
    mix_word[WORD_W-2 -: ACC_W] = acc;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    acc_n   = acc;
    snap_n  = snap;
    word_n  = i2s_word;
    unique case (state)
      IDLE: state_n = START;
      START: begin
        snap_n  = voice_active;
        acc_n   = '0;
        idx_n   = '0;
        state_n = SCAN;
      end
      SCAN: begin
        if (snap[idx])
          state_n = REQ;
        else if (last)
          state_n = DONE;
        else
          idx_n = idx + IW'(1);
      end
      REQ: begin
        if (fetch_ack) begin
          acc_n   = acc + sample_ext;
          state_n = GAP;
        end
      end
      GAP: begin
        if (last) begin
          state_n = DONE;
        end else begin
          idx_n   = idx + IW'(1);
          state_n = SCAN;
        end
      end
      DONE: state_n = DONE;
      default: state_n = IDLE;
    endcase
    // Frame boundary overrides: publish a finished round or abort a late one
    if (frame_start) begin
      word_n  = (state == DONE) ? mix_word : '0;
      state_n = START;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= '0;
      snap     <= '0;
      i2s_word <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      acc      <= acc_n;
      snap     <= snap_n;
      i2s_word <= word_n;
    end
  end

endmodule

// File: tb/tb_i2s_mix_sched.sv
// Frame-level bench for i2s_mix_sched: table vectors, random
// frames against a sum-of-samples model, reset/enable sequences.
module tb_i2s_mix_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  voice_active = '0;
  logic        fetch_req;
  logic [1:0]  fetch_voice;
  logic        fetch_ack = 1'b0;
  logic [7:0]  fetch_data = '0;
  logic        sclk, lrclk;
  logic [31:0] i2s_word;
  logic        frame_start, underrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  i2s_mix_sched dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .voice_active (voice_active),
    .fetch_req    (fetch_req),
    .fetch_voice  (fetch_voice),
    .fetch_ack    (fetch_ack),
    .fetch_data   (fetch_data),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .i2s_word     (i2s_word),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          lat;
    bit          mute;
    bit          stray;
    bit          toggle;
    logic [31:0] exp_word;
    bit          exp_under;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs the responder until the next frame_start, then checks
  // the boundary and the word published one cycle later.
  task automatic do_frame(input vec_t v, input int off, input int exp_n);
    int n = 0;
    int waited = 0;
    int clk_bad = 0;
    int c;
    int sig_g = 0;
    int sig_w = 0;
    bit prev = 0;
    logic [1:0] got[$];
    logic [1:0] want[$];
    voice_active = v.mask;
    fetch_ack = 1'b0;
    forever begin
      c = (off + n) % 512;
      if (sclk !== 1'((c / 4) % 2) || lrclk !== 1'((c / 256) % 2))
        clk_bad++;
      if (frame_start === 1'b1 || n >= 700) break;
      if (v.toggle && n == 1) voice_active = ~v.mask;
      if (fetch_req === 1'b1) begin
        if (!prev) begin
          got.push_back(fetch_voice);
          waited = 0;
        end
        fetch_ack  = !v.mute && (waited == v.lat);
        fetch_data = v.data[int'(fetch_voice)*8 +: 8];
        waited++;
      end else begin
        fetch_ack  = v.stray && ($urandom_range(0, 1) == 1);
        fetch_data = 8'($urandom);
      end
      prev = fetch_req;
      @(negedge clk);
      n++;
    end
    fetch_ack = 1'b0;
    check("frame_len", n, exp_n);
    check("clocks", clk_bad, 0);
    check("underrun_at_fs", underrun, v.exp_under);
    for (int k = 0; k < 4; k++)
      if (v.mask[k]) want.push_back(2'(k));
    if (v.mute && want.size() > 1) want = want[0:0];
    foreach (got[i]) sig_g = sig_g * 5 + int'(got[i]) + 1;
    foreach (want[i]) sig_w = sig_w * 5 + int'(want[i]) + 1;
    check("req_order", sig_g, sig_w);
    @(negedge clk);
    check("word", i2s_word, v.exp_word);
    check("underrun_1cyc", underrun, 1'b0);
    check("fs_1cyc", frame_start, 1'b0);
    check("req_after_fs", fetch_req, 1'b0);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    int s = 0;
    v.mask   = 4'($urandom);
    v.data   = $urandom;
    v.lat    = $urandom_range(0, 20);
    v.mute   = ($urandom_range(0, 7) == 0);
    v.stray  = 1'($urandom);
    v.toggle = 1'($urandom);
    for (int k = 0; k < 4; k++)
      if (v.mask[k]) s += int'($signed(v.data[k*8 +: 8]));
    v.exp_under = v.mute && (v.mask != 0);
    v.exp_word  = v.exp_under ? 32'h0 : 32'((s & 32'h3FF) << 21);
    return v;
  endfunction

  initial begin
    int w;
    tbl[0] = '{4'b0001, 32'hAABBCC40, 3, 0, 0, 0, 32'h0800_0000, 0};
    tbl[1] = '{4'b1111, 32'h7F7F7F7F, 0, 0, 0, 0, 32'h3F80_0000, 0};
    tbl[2] = '{4'b1111, 32'h80808080, 1, 0, 1, 0, 32'h4000_0000, 0};
    tbl[3] = '{4'b1010, 32'h0155FF33, 2, 0, 1, 1, 32'h0000_0000, 0};
    tbl[4] = '{4'b0001, 32'h00000040, 0, 1, 0, 0, 32'h0000_0000, 1};
    tbl[5] = '{4'b0001, 32'h00000040, 3, 0, 0, 0, 32'h0800_0000, 0};
    tbl[6] = '{4'b0000, 32'h12345678, 0, 1, 1, 0, 32'h0000_0000, 0};
    tbl[7] = '{4'b0110, 32'h11030522, 5, 0, 1, 0, 32'h0100_0000, 0};

    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctl", {sclk, lrclk, fetch_req, fetch_voice, frame_start,
                      underrun}, 0);
    check("rst_word", i2s_word, 0);
    reset = 1'b0;
    do_frame(tbl[0], 0, 512);
    for (int i = 1; i < 8; i++) do_frame(tbl[i], 1, 511);

    for (int i = 0; i < 12; i++) do_frame(rand_vec(), 1, 511);

    do_frame(tbl[0], 1, 511);
    voice_active = 4'b0010;
    fetch_ack = 1'b0;
    w = 0;
    while (fetch_req !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_seen", fetch_req, 1'b1);
    check("req_voice", fetch_voice, 2'd1);
    check("word_held", i2s_word, 32'h0800_0000);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_ctl", {sclk, lrclk, fetch_req, fetch_voice, frame_start,
                          underrun}, 0);
    check("rst_mid_word", i2s_word, 0);
    reset = 1'b0;
    do_frame(tbl[5], 0, 512);

    enable = 1'b0;
    @(negedge clk);
    check("en_low_ctl", {sclk, lrclk, fetch_req, fetch_voice, frame_start,
                         underrun}, 0);
    check("en_low_word", i2s_word, 0);
    enable = 1'b1;
    do_frame(tbl[1], 0, 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
